// File: rtl/syn_sram_acc_arb.sv
// Arbiter and pin sequencer for a 256Kx16 asynchronous SRAM shared by the
// GPU pixel gateway (byte read/write) and the VGA frame fetch (word reads).
module syn_sram_acc_arb #(
    parameter int P_SRAM_ADDR_W    = 18,
    parameter int P_GPU_ADDR_W     = 19,
    parameter int P_GPU_STARVE_MAX = 8
) (
    input  logic                     clk_ir,
    input  logic                     rst_sync_l,
    input  logic [P_GPU_ADDR_W-1:0]  gpu_addr,
    input  logic                     gpu_rd_en,
    input  logic                     gpu_wr_en,
    input  logic [7:0]               gpu_wr_data,
    output logic                     gpu_rdy,
    output logic                     gpu_rd_valid,
    output logic [7:0]               gpu_rd_data,
    input  logic [P_SRAM_ADDR_W-1:0] vga_addr,
    input  logic                     vga_rd_en,
    output logic                     vga_rdy,
    output logic                     vga_rd_valid,
    output logic [15:0]              vga_rd_data,
    output logic [P_SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]              sram_dq_o,
    output logic                     sram_dq_oe,
    input  logic [15:0]              sram_dq_i,
    output logic                     sram_ce_n,
    output logic                     sram_oe_n,
    output logic                     sram_we_n,
    output logic                     sram_ub_n,
    output logic                     sram_lb_n
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_WR     = 2'd2,
        ST_WR_REC = 2'd3
    } state_e;

    localparam int LP_STARVE_W = $clog2(P_GPU_STARVE_MAX + 1);
    localparam logic [LP_STARVE_W-1:0] LP_STARVE_MAX = LP_STARVE_W'(P_GPU_STARVE_MAX);

    // Pick the byte lane addressed by the low GPU address bit.
    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
        lane_byte = lane ? word[15:8] : word[7:0];
    endfunction

    state_e                   state_q, state_d;
    logic [LP_STARVE_W-1:0]   starve_q, starve_d;
    logic [P_SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]              dq_o_q, dq_o_d;
    logic                     dq_oe_q, dq_oe_d;
    logic                     ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                     ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic                     tag_vld_q, tag_vld_d, tag_gpu_q, tag_gpu_d, tag_lane_q, tag_lane_d;
    logic                     gpu_rd_valid_q, gpu_rd_valid_d, vga_rd_valid_q, vga_rd_valid_d;
    logic [7:0]               gpu_rd_data_q, gpu_rd_data_d;
    logic [15:0]              vga_rd_data_q, vga_rd_data_d;

    logic accept_s, gpu_req_s, gpu_win_s, vga_win_s, turn_block_s;
    logic grant_gpu_s, grant_vga_s;

    // Arbitration: VGA first unless the GPU has been starved to the limit.
    always_comb begin
        accept_s  = (state_q != ST_WR);
        gpu_req_s = gpu_rd_en | gpu_wr_en;
        gpu_win_s = 1'b0;
        vga_win_s = 1'b0;
        if (!accept_s) begin
            gpu_win_s = 1'b0;
            vga_win_s = 1'b0;
        end else if (gpu_req_s && (starve_q == LP_STARVE_MAX)) begin
            gpu_win_s = 1'b1;
        end else if (vga_rd_en) begin
            vga_win_s = 1'b1;
        end else if (gpu_req_s) begin
            gpu_win_s = 1'b1;
        end else begin
            gpu_win_s = 1'b0;
            vga_win_s = 1'b0;
        end
        // A write right behind a read waits one cycle so dq is never fought over.
        turn_block_s = gpu_win_s & gpu_wr_en & (state_q == ST_RD);
        grant_gpu_s  = gpu_win_s & ~turn_block_s & rst_sync_l;
        grant_vga_s  = vga_win_s & rst_sync_l;
    end

    // Starvation counter for the GPU requester.
    always_comb begin
        starve_d = starve_q;
        if (grant_gpu_s) begin
            starve_d = {LP_STARVE_W{1'b0}};
        end else if (gpu_req_s && (starve_q != LP_STARVE_MAX)) begin
            starve_d = starve_q + LP_STARVE_W'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Next state and registered SRAM pin values.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        dq_oe_d    = dq_oe_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        ub_n_d     = ub_n_q;
        lb_n_d     = lb_n_q;
        tag_vld_d  = 1'b0;
        tag_gpu_d  = 1'b0;
        tag_lane_d = 1'b0;
        case (state_q)
            ST_WR: begin
                state_d = ST_WR_REC;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b1;
            end
            ST_IDLE, ST_RD, ST_WR_REC: begin
                if (grant_gpu_s && gpu_wr_en) begin
                    state_d = ST_WR;
                    addr_d  = gpu_addr[P_GPU_ADDR_W-1:1];
                    dq_o_d  = {gpu_wr_data, gpu_wr_data};
                    dq_oe_d = 1'b1;
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b0;
                    ub_n_d  = ~gpu_addr[0];
                    lb_n_d  = gpu_addr[0];
                end else if (grant_gpu_s) begin
                    state_d    = ST_RD;
                    addr_d     = gpu_addr[P_GPU_ADDR_W-1:1];
                    dq_oe_d    = 1'b0;
                    ce_n_d     = 1'b0;
                    oe_n_d     = 1'b0;
                    we_n_d     = 1'b1;
                    ub_n_d     = ~gpu_addr[0];
                    lb_n_d     = gpu_addr[0];
                    tag_vld_d  = 1'b1;
                    tag_gpu_d  = 1'b1;
                    tag_lane_d = gpu_addr[0];
                end else if (grant_vga_s) begin
                    state_d   = ST_RD;
                    addr_d    = vga_addr;
                    dq_oe_d   = 1'b0;
                    ce_n_d    = 1'b0;
                    oe_n_d    = 1'b0;
                    we_n_d    = 1'b1;
                    ub_n_d    = 1'b0;
                    lb_n_d    = 1'b0;
                    tag_vld_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    dq_oe_d = 1'b0;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dq_oe_d = 1'b0;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                lb_n_d  = 1'b1;
            end
        endcase
    end

    // Read return: dq sampled one cycle after the pins were driven.
    always_comb begin
        gpu_rd_valid_d = tag_vld_q & tag_gpu_q;
        vga_rd_valid_d = tag_vld_q & ~tag_gpu_q;
        gpu_rd_data_d  = gpu_rd_data_q;
        vga_rd_data_d  = vga_rd_data_q;
        if (gpu_rd_valid_d) begin
            gpu_rd_data_d = lane_byte(sram_dq_i, tag_lane_q);
        end else begin
            gpu_rd_data_d = gpu_rd_data_q;
        end
        if (vga_rd_valid_d) begin
            vga_rd_data_d = sram_dq_i;
        end else begin
            vga_rd_data_d = vga_rd_data_q;
        end
    end

    // State, pin and return-pipeline registers.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_q        <= ST_IDLE;
            starve_q       <= {LP_STARVE_W{1'b0}};
            addr_q         <= {P_SRAM_ADDR_W{1'b0}};
            dq_o_q         <= 16'h0000;
            dq_oe_q        <= 1'b0;
            ce_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
            ub_n_q         <= 1'b1;
            lb_n_q         <= 1'b1;
            tag_vld_q      <= 1'b0;
            tag_gpu_q      <= 1'b0;
            tag_lane_q     <= 1'b0;
            gpu_rd_valid_q <= 1'b0;
            vga_rd_valid_q <= 1'b0;
            gpu_rd_data_q  <= 8'h00;
            vga_rd_data_q  <= 16'h0000;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            addr_q         <= addr_d;
            dq_o_q         <= dq_o_d;
            dq_oe_q        <= dq_oe_d;
            ce_n_q         <= ce_n_d;
            oe_n_q         <= oe_n_d;
            we_n_q         <= we_n_d;
            ub_n_q         <= ub_n_d;
            lb_n_q         <= lb_n_d;
            tag_vld_q      <= tag_vld_d;
            tag_gpu_q      <= tag_gpu_d;
            tag_lane_q     <= tag_lane_d;
            gpu_rd_valid_q <= gpu_rd_valid_d;
            vga_rd_valid_q <= vga_rd_valid_d;
            gpu_rd_data_q  <= gpu_rd_data_d;
            vga_rd_data_q  <= vga_rd_data_d;
        end
    end

    assign gpu_rdy      = grant_gpu_s;
    assign vga_rdy      = grant_vga_s;
    assign gpu_rd_valid = gpu_rd_valid_q;
    assign gpu_rd_data  = gpu_rd_data_q;
    assign vga_rd_valid = vga_rd_valid_q;
    assign vga_rd_data  = vga_rd_data_q;
    assign sram_addr    = addr_q;
    assign sram_dq_o    = dq_o_q;
    assign sram_dq_oe   = dq_oe_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign sram_ub_n    = ub_n_q;
    assign sram_lb_n    = lb_n_q;

endmodule

// File: tb/tb_syn_sram_acc_arb.sv
// Directed bench for syn_sram_acc_arb: linear stimulus, immediate-assertion checks.
module tb_syn_sram_acc_arb;

    logic        clk_ir = 1'b0;
    logic        rst_sync_l = 1'b0;
    logic [18:0] gpu_addr = 19'h0;
    logic        gpu_rd_en = 1'b0, gpu_wr_en = 1'b0;
    logic [7:0]  gpu_wr_data = 8'h00;
    logic        gpu_rdy, gpu_rd_valid;
    logic [7:0]  gpu_rd_data;
    logic [17:0] vga_addr = 18'h0;
    logic        vga_rd_en = 1'b0;
    logic        vga_rdy, vga_rd_valid;
    logic [15:0] vga_rd_data;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic        use_model = 1'b0;
    logic [15:0] dq_fix = 16'hA55A;
    int          n_checks = 0;
    int          n_errors = 0;
    int          bus_clash_cnt = 0;
    int          proto_cnt = 0;

    // SRAM stand-in: either a fixed word or a pattern derived from the address.
    assign sram_dq_i = use_model ? {8'hC3, sram_addr[7:0]} : dq_fix;

    syn_sram_acc_arb dut (
        .clk_ir(clk_ir), .rst_sync_l(rst_sync_l),
        .gpu_addr(gpu_addr), .gpu_rd_en(gpu_rd_en), .gpu_wr_en(gpu_wr_en),
        .gpu_wr_data(gpu_wr_data), .gpu_rdy(gpu_rdy), .gpu_rd_valid(gpu_rd_valid),
        .gpu_rd_data(gpu_rd_data), .vga_addr(vga_addr), .vga_rd_en(vga_rd_en),
        .vga_rdy(vga_rdy), .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk_ir = ~clk_ir;

    // Bus-contention and protocol-error monitors, sampled on the falling edge.
    always @(negedge clk_ir) begin
        if (rst_sync_l && sram_dq_oe && !sram_oe_n) bus_clash_cnt <= bus_clash_cnt + 1;
        if (rst_sync_l && gpu_rd_en && gpu_wr_en) proto_cnt <= proto_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ir);
        #1;
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_ce_n"}, 32'(sram_ce_n), 32'h1);
        check({tag, "_oe_n"}, 32'(sram_oe_n), 32'h1);
        check({tag, "_we_n"}, 32'(sram_we_n), 32'h1);
        check({tag, "_ub_n"}, 32'(sram_ub_n), 32'h1);
        check({tag, "_lb_n"}, 32'(sram_lb_n), 32'h1);
        check({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'h0);
    endtask

    initial begin
        // Reset state, with a GPU write request held to prove rdy stays low.
        gpu_wr_en = 1'b1;
        tick(); tick();
        #1;
        check_idle_pins("rst");
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_dq_o", 32'(sram_dq_o), 32'h0);
        check("rst_gpu_rdy", 32'(gpu_rdy), 32'h0);
        check("rst_vga_rdy", 32'(vga_rdy), 32'h0);
        check("rst_gpu_vld", 32'(gpu_rd_valid), 32'h0);
        check("rst_vga_vld", 32'(vga_rd_valid), 32'h0);
        check("rst_gpu_data", 32'(gpu_rd_data), 32'h0);
        check("rst_vga_data", 32'(vga_rd_data), 32'h0);
        gpu_wr_en = 1'b0;
        tick();
        rst_sync_l = 1'b1;
        tick();

        // GPU byte write to the upper lane.
        gpu_addr = 19'h00003; gpu_wr_data = 8'hA5; gpu_wr_en = 1'b1;
        #1 check("wr_rdy", 32'(gpu_rdy), 32'h1);
        tick();
        gpu_wr_en = 1'b0;
        #1;
        check("wr_addr", 32'(sram_addr), 32'h1);
        check("wr_we_n", 32'(sram_we_n), 32'h0);
        check("wr_ub_n", 32'(sram_ub_n), 32'h0);
        check("wr_lb_n", 32'(sram_lb_n), 32'h1);
        check("wr_dq_o", 32'(sram_dq_o), 32'hA5A5);
        check("wr_dq_oe", 32'(sram_dq_oe), 32'h1);
        check("wr_oe_n", 32'(sram_oe_n), 32'h1);
        check("wr_ce_n", 32'(sram_ce_n), 32'h0);
        tick();
        #1;
        check("wrrec_we_n", 32'(sram_we_n), 32'h1);
        check("wrrec_dq_oe", 32'(sram_dq_oe), 32'h1);
        check("wrrec_addr", 32'(sram_addr), 32'h1);
        tick();
        #1 check_idle_pins("wr_idle");

        // GPU reads of both lanes from a fixed SRAM word.
        dq_fix = 16'hA55A;
        for (int k = 0; k < 2; k++) begin
            gpu_addr = (k == 0) ? 19'h00003 : 19'h00002;
            gpu_rd_en = 1'b1;
            #1 check("rd_rdy", 32'(gpu_rdy), 32'h1);
            tick();
            gpu_rd_en = 1'b0;
            #1;
            check("rd_addr", 32'(sram_addr), 32'h1);
            check("rd_oe_n", 32'(sram_oe_n), 32'h0);
            check("rd_ce_n", 32'(sram_ce_n), 32'h0);
            check("rd_ub_n", 32'(sram_ub_n), (k == 0) ? 32'h0 : 32'h1);
            check("rd_lb_n", 32'(sram_lb_n), (k == 0) ? 32'h1 : 32'h0);
            check("rd_vld_early", 32'(gpu_rd_valid), 32'h0);
            tick();
            #1;
            check("rd_vld", 32'(gpu_rd_valid), 32'h1);
            check("rd_data", 32'(gpu_rd_data), (k == 0) ? 32'hA5 : 32'h5A);
            check("rd_vga_vld", 32'(vga_rd_valid), 32'h0);
            tick();
            #1 check("rd_vld_end", 32'(gpu_rd_valid), 32'h0);
        end

        // VGA burst of 16 back-to-back reads.
        use_model = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vga_addr = 18'(i); vga_rd_en = 1'b1;
            #1;
            check("vga_rdy", 32'(vga_rdy), 32'h1);
            if (i >= 1) check("vga_addr", 32'(sram_addr), 32'(i - 1));
            if (i >= 2) begin
                check("vga_vld", 32'(vga_rd_valid), 32'h1);
                check("vga_data", 32'(vga_rd_data), 32'hC300 | 32'(i - 2));
            end
            tick();
        end
        vga_rd_en = 1'b0;
        #1;
        check("vga_addr_last", 32'(sram_addr), 32'hF);
        check("vga_data_14", 32'(vga_rd_data), 32'hC30E);
        tick();
        #1;
        check("vga_vld_15", 32'(vga_rd_valid), 32'h1);
        check("vga_data_15", 32'(vga_rd_data), 32'hC30F);
        tick();
        #1 check("vga_vld_end", 32'(vga_rd_valid), 32'h0);
        tick();

        // GPU read starved by a continuous VGA stream; forced slot on the 9th cycle.
        vga_addr = 18'h00100; gpu_addr = 19'h00011; gpu_rd_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            vga_rd_en = 1'b1;
            #1;
            check("stv_gpu_rdy", 32'(gpu_rdy), (k == 9) ? 32'h1 : 32'h0);
            check("stv_vga_rdy", 32'(vga_rdy), (k == 9) ? 32'h0 : 32'h1);
            if (k == 10) begin
                check("stv_addr", 32'(sram_addr), 32'h8);
                check("stv_ub_n", 32'(sram_ub_n), 32'h0);
                check("stv_lb_n", 32'(sram_lb_n), 32'h1);
                check("stv_vga_vld10", 32'(vga_rd_valid), 32'h1);
            end
            if (k == 11) begin
                check("stv_gpu_vld", 32'(gpu_rd_valid), 32'h1);
                check("stv_gpu_data", 32'(gpu_rd_data), 32'hC3);
                check("stv_vga_vld11", 32'(vga_rd_valid), 32'h0);
            end
            if (k == 12) check("stv_vga_vld12", 32'(vga_rd_valid), 32'h1);
            tick();
            if (k == 9) gpu_rd_en = 1'b0;
        end
        vga_rd_en = 1'b0;
        tick(); tick(); tick();

        // Read followed by a write: one turnaround IDLE cycle.
        vga_addr = 18'h00005; vga_rd_en = 1'b1;
        gpu_addr = 19'h00004; gpu_wr_data = 8'h3C; gpu_wr_en = 1'b1;
        #1;
        check("ta_vga_rdy", 32'(vga_rdy), 32'h1);
        check("ta_gpu_rdy0", 32'(gpu_rdy), 32'h0);
        tick();
        vga_rd_en = 1'b0;
        #1;
        check("ta_gpu_rdy1", 32'(gpu_rdy), 32'h0);
        check("ta_rd_oe_n", 32'(sram_oe_n), 32'h0);
        check("ta_rd_dq_oe", 32'(sram_dq_oe), 32'h0);
        tick();
        #1;
        check("ta_gpu_rdy2", 32'(gpu_rdy), 32'h1);
        check_idle_pins("ta_idle");
        check("ta_vga_vld", 32'(vga_rd_valid), 32'h1);
        check("ta_vga_data", 32'(vga_rd_data), 32'hC305);
        tick();
        gpu_wr_en = 1'b0;
        #1;
        check("ta_we_n", 32'(sram_we_n), 32'h0);
        check("ta_dq_oe", 32'(sram_dq_oe), 32'h1);
        check("ta_oe_n", 32'(sram_oe_n), 32'h1);
        check("ta_dq_o", 32'(sram_dq_o), 32'h3C3C);
        check("ta_addr", 32'(sram_addr), 32'h2);
        check("ta_lb_n", 32'(sram_lb_n), 32'h0);
        check("ta_ub_n", 32'(sram_ub_n), 32'h1);
        tick(); tick();

        // Read and write requested together: handled as a write, no read return.
        gpu_addr = 19'h00006; gpu_wr_data = 8'h77; gpu_rd_en = 1'b1; gpu_wr_en = 1'b1;
        #1 check("both_rdy", 32'(gpu_rdy), 32'h1);
        tick();
        gpu_rd_en = 1'b0; gpu_wr_en = 1'b0;
        #1;
        check("both_we_n", 32'(sram_we_n), 32'h0);
        check("both_dq_o", 32'(sram_dq_o), 32'h7777);
        tick();
        #1 check("both_no_vld", 32'(gpu_rd_valid), 32'h0);
        tick();
        #1 check("both_no_vld2", 32'(gpu_rd_valid), 32'h0);
        check("proto_flag", 32'(proto_cnt), 32'h1);

        // Reset with two reads in flight: strobes drop at once, nothing returns.
        vga_addr = 18'h00007; vga_rd_en = 1'b1;
        #1 check("mr_rdy0", 32'(vga_rdy), 32'h1);
        tick();
        vga_addr = 18'h00008;
        #1 check("mr_rdy1", 32'(vga_rdy), 32'h1);
        check("mr_ce_n_pre", 32'(sram_ce_n), 32'h0);
        vga_rd_en = 1'b0;
        #1 rst_sync_l = 1'b0;
        #1;
        check_idle_pins("mr_rst");
        tick(); tick();
        rst_sync_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            check("mr_vga_vld", 32'(vga_rd_valid), 32'h0);
            check("mr_gpu_vld", 32'(gpu_rd_valid), 32'h0);
        end
        check("mr_vga_data", 32'(vga_rd_data), 32'h0);

        // Reset during the write pulse aborts it immediately.
        gpu_addr = 19'h00000; gpu_wr_data = 8'h11; gpu_wr_en = 1'b1;
        #1 check("wa_rdy", 32'(gpu_rdy), 32'h1);
        tick();
        gpu_wr_en = 1'b0;
        #1 check("wa_we_n_pre", 32'(sram_we_n), 32'h0);
        rst_sync_l = 1'b0;
        #1 check_idle_pins("wa_rst");
        tick();
        rst_sync_l = 1'b1;
        tick();
        #1 check_idle_pins("wa_after");

        check("bus_clash", 32'(bus_clash_cnt), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
